// File: rtl/cf_seq_div.sv
// Multi-cycle unsigned divider (radix-2 restoring, one quotient bit per cycle)
// with floor/ceil rounding and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// BUSY  | iterating, one quotient bit per cycle
// DONE  | result presented, waiting for out_ready_i
module cf_seq_div #(
  parameter int WIDTH = 32,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             ceil_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   prem;
  logic [CNT_W-1:0]   cnt;
  logic               ceil_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic               dz_q;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     prem_sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   prem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               inc;
  logic [WIDTH-1:0]   quo_fin;

  // The stored remainder is always < divisor, so only the shifted value needs
  // the extra bit; the difference is exact modulo 2^WIDTH whenever ge is set.
  always_comb begin
    prem_sh = {prem, dvd[WIDTH-1]};
    ge      = (prem_sh >= {1'b0, dvs});
    diff    = prem_sh[WIDTH-1:0] - dvs;
    prem_nx = ge ? diff : prem_sh[WIDTH-1:0];
    quo_nx  = {dvd[WIDTH-2:0], ge};
    inc     = ceil_q && (prem_nx != '0);
    quo_fin = quo_nx + {{(WIDTH-1){1'b0}}, inc};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    accept      = 1'b0;
    last        = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept   = 1'b1;
          state_nx = (divisor_i == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      cnt    <= '0;
      ceil_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      dvd    <= dividend_i;
      dvs    <= divisor_i;
      ceil_q <= ceil_i;
      prem   <= '0;
      cnt    <= CNT_W'(WIDTH - 1);
      if (divisor_i == '0) begin
        quo_q <= '1;
        rem_q <= dividend_i;
        dz_q  <= 1'b1;
      end else begin
        dz_q  <= 1'b0;
      end
    end else if (state == BUSY) begin
      prem <= prem_nx;
      dvd  <= quo_nx;
      cnt  <= cnt - 1'b1;
      // result registers change only on completion so no partial value leaks out
      if (last) begin
        quo_q <= quo_fin;
        rem_q <= prem_nx;
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_cf_seq_div.sv
// Bench for cf_seq_div: an 8-bit instance for directed cases and a 32-bit
// instance for a random regression, both checked every cycle against a model.
module tb_cf_seq_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_ceil, a_ovalid, a_oready, a_dz;
  logic [7:0] a_dvd, a_dvs, a_q, a_r;
  logic        b_valid, b_ready, b_ceil, b_ovalid, b_oready, b_dz;
  logic [31:0] b_dvd, b_dvs, b_q, b_r;

  cf_seq_div #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_valid), .in_ready_o(a_ready),
    .dividend_i(a_dvd), .divisor_i(a_dvs), .ceil_i(a_ceil),
    .out_valid_o(a_ovalid), .out_ready_i(a_oready),
    .quotient_o(a_q), .remainder_o(a_r), .div_zero_o(a_dz));

  cf_seq_div #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_valid), .in_ready_o(b_ready),
    .dividend_i(b_dvd), .divisor_i(b_dvs), .ceil_i(b_ceil),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready),
    .quotient_o(b_q), .remainder_o(b_r), .div_zero_o(b_dz));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } res_t;

  // Plain arithmetic reference: ceil via (a+b-1)/b, divide-by-zero convention.
  function automatic res_t ref_div(input logic [63:0] a, input logic [63:0] b,
                                   input logic c, input int w);
    res_t res;
    if (b == 0) begin
      res.q  = (64'd1 << w) - 64'd1;
      res.r  = a;
      res.dz = 1'b1;
    end else begin
      res.q  = c ? (a + b - 64'd1) / b : a / b;
      res.r  = a % b;
      res.dz = 1'b0;
    end
    return res;
  endfunction

  // Model state per instance: pending op, edges since accept, expected latency,
  // expected result and the value the outputs must hold outside DONE.
  logic m8_pend, m32_pend;
  int   m8_age, m8_lat, m32_age, m32_lat;
  res_t m8_exp, m8_hold, m32_exp, m32_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_pend <= 1'b0;  m8_age <= 0;  m8_lat <= 0;  m8_exp <= '0;  m8_hold <= '0;
      m32_pend <= 1'b0; m32_age <= 0; m32_lat <= 0; m32_exp <= '0; m32_hold <= '0;
    end else begin
      if (m8_pend) begin
        if (m8_age >= m8_lat && a_oready) begin
          m8_pend <= 1'b0;
          m8_hold <= m8_exp;
        end else m8_age <= m8_age + 1;
      end else if (a_valid) begin
        m8_exp     <= ref_div(64'(a_dvd), 64'(a_dvs), a_ceil, 8);
        m8_pend    <= 1'b1;
        m8_age     <= 1;
        m8_lat     <= (a_dvs == 0) ? 1 : 9;
        m8_hold.dz <= 1'b0;
      end
      if (m32_pend) begin
        if (m32_age >= m32_lat && b_oready) begin
          m32_pend <= 1'b0;
          m32_hold <= m32_exp;
        end else m32_age <= m32_age + 1;
      end else if (b_valid) begin
        m32_exp     <= ref_div(64'(b_dvd), 64'(b_dvs), b_ceil, 32);
        m32_pend    <= 1'b1;
        m32_age     <= 1;
        m32_lat     <= (b_dvs == 0) ? 1 : 33;
        m32_hold.dz <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid8", a_ovalid, m8_pend && m8_age >= m8_lat);
      chk("ready8", a_ready, !m8_pend);
      chk("quot8",  a_q,  (m8_pend && m8_age >= m8_lat) ? m8_exp.q[7:0] : m8_hold.q[7:0]);
      chk("rem8",   a_r,  (m8_pend && m8_age >= m8_lat) ? m8_exp.r[7:0] : m8_hold.r[7:0]);
      chk("dz8",    a_dz, (m8_pend && m8_age >= m8_lat) ? m8_exp.dz : m8_hold.dz);
      chk("valid32", b_ovalid, m32_pend && m32_age >= m32_lat);
      chk("ready32", b_ready, !m32_pend);
      chk("quot32",  b_q,  (m32_pend && m32_age >= m32_lat) ? m32_exp.q[31:0] : m32_hold.q[31:0]);
      chk("rem32",   b_r,  (m32_pend && m32_age >= m32_lat) ? m32_exp.r[31:0] : m32_hold.r[31:0]);
      chk("dz32",    b_dz, (m32_pend && m32_age >= m32_lat) ? m32_exp.dz : m32_hold.dz);
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz,
                      input int hold, input logic early);
    int edges;
    @(posedge clk); #1;
    a_dvd = a; a_dvs = b; a_ceil = c; a_valid = 1'b1; a_oready = early;
    @(posedge clk); #1;
    a_valid = 1'b0; a_dvd = 8'($urandom); a_dvs = 8'($urandom); a_ceil = 1'($urandom);
    edges = 1;
    while (!a_ovalid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency8", 64'(edges), (b == 0) ? 64'd1 : 64'd9);
    chk("lit_q8", a_q, eq);
    chk("lit_r8", a_r, er);
    chk("lit_dz8", a_dz, edz);
    repeat (hold) @(posedge clk);
    if (hold > 0) begin
      #1;
      chk("hold_valid8", a_ovalid, 1'b1);
      chk("hold_q8", a_q, eq);
      chk("hold_ready8", a_ready, 1'b0);
    end
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0;
    chk("back_idle8", a_ready, 1'b1);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output logic [31:0] q, output logic [31:0] r);
    int edges;
    @(posedge clk); #1;
    b_dvd = a; b_dvs = b; b_ceil = c; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_dvd = $urandom; b_dvs = $urandom;
    edges = 1;
    while (!b_ovalid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency32", 64'(edges), (b == 0) ? 64'd1 : 64'd33);
    q = b_q;
    r = b_r;
    b_oready = 1'b1;
    @(posedge clk); #1;
    b_oready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q32, r32, x, y;
    a_valid = 0; a_dvd = 0; a_dvs = 0; a_ceil = 0; a_oready = 0;
    b_valid = 0; b_dvd = 0; b_dvs = 0; b_ceil = 0; b_oready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_valid", a_ovalid, 1'b0);
    chk("rst_q", a_q, 8'd0);
    chk("rst_dz", a_dz, 1'b0);
    rst_n = 1'b1;

    run8(8'd100, 8'd7,   1'b0, 8'd14,  8'd2, 1'b0, 0, 1'b0);
    run8(8'd100, 8'd7,   1'b1, 8'd15,  8'd2, 1'b0, 0, 1'b0);
    run8(8'd84,  8'd7,   1'b1, 8'd12,  8'd0, 1'b0, 0, 1'b1);
    run8(8'd255, 8'd1,   1'b1, 8'd255, 8'd0, 1'b0, 0, 1'b0);
    run8(8'd0,   8'd5,   1'b1, 8'd0,   8'd0, 1'b0, 0, 1'b0);
    run8(8'd3,   8'd200, 1'b1, 8'd1,   8'd3, 1'b0, 0, 1'b1);
    run8(8'd3,   8'd200, 1'b0, 8'd0,   8'd3, 1'b0, 0, 1'b0);
    run8(8'd255, 8'd255, 1'b1, 8'd1,   8'd0, 1'b0, 0, 1'b0);
    run8(8'd9,   8'd0,   1'b0, 8'd255, 8'd9, 1'b1, 0, 1'b0);
    run8(8'd10,  8'd3,   1'b0, 8'd3,   8'd1, 1'b0, 0, 1'b0);
    run8(8'd200, 8'd9,   1'b0, 8'd22,  8'd2, 1'b0, 20, 1'b0);
    run8(8'd200, 8'd9,   1'b1, 8'd23,  8'd2, 1'b0, 0, 1'b0);

    // abort mid-BUSY; outputs currently hold 23/2
    @(posedge clk); #1;
    a_dvd = 8'd200; a_dvs = 8'd3; a_ceil = 1'b0; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_q", a_q, 8'd0);
    chk("abort_r", a_r, 8'd0);
    chk("abort_ready", a_ready, 1'b1);
    chk("abort_valid", a_ovalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_valid", a_ovalid, 1'b0);
    run8(8'd77, 8'd10, 1'b1, 8'd8, 8'd7, 1'b0, 0, 1'b0);

    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, q32, r32);
    chk("lit_max32_q", q32, 32'd1);
    chk("lit_max32_r", r32, 32'd0);
    run32(32'd1_000_000, 32'd7, 1'b1, q32, r32);
    chk("lit_1e6_q", q32, 32'd142858);
    chk("lit_1e6_r", r32, 32'd1);
    run32(32'd1_000_000, 32'd7, 1'b0, q32, r32);
    chk("lit_1e6f_q", q32, 32'd142857);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case (i % 5)
        0: y = $urandom;
        1: y = 32'($urandom_range(1, 15));
        2: y = $urandom & 32'h0000_FFFF;
        3: y = (i == 8) ? 32'd0 : 32'($urandom_range(1, 1000));
        default: begin y = x; x = (i % 2 == 0) ? x : x >> 4; end
      endcase
      run32(x, y, 1'($urandom), q32, r32);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
